// File: rtl/freq_req_if.sv
// ============================================================================
// Module   : freq_req_if
// Brief    : Target-frequency request channel (valid/ready with 8-bit index).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface freq_req_if;
   logic       req_valid_i;
   logic [7:0] req_data_i;
   logic       req_ready_o;

   modport master (
      output req_valid_i,
      output req_data_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_data_i,
      output req_ready_o
   );
endinterface

`default_nettype wire

// File: rtl/freq_req_governor.sv
// ============================================================================
// Module   : freq_req_governor
// Brief    : Sequences frequency-index changes to a clock manager, waiting for
//            lock and a dwell period between issues. Optional step limiting is
//            compiled in with macro FREQ_REQ_STEP_LIMIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_req_governor #(
   parameter int N_FREQ       = 20,
   parameter int INIT_FREQ    = 19,
   parameter int LOCK_HOLDOFF = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int DWELL_CYCLES = 1024,
   parameter int MAX_STEP     = 4
) (
   input  logic        clk,
   input  logic        rst,
   freq_req_if.slave   req,
   input  logic        mmcm_locked_i,
   output logic [7:0]  freq_data_o,
   output logic        freq_valid_o,
   output logic [7:0]  cur_freq_o,
   output logic        busy_o,
   output logic        range_err_o,
   output logic        timeout_err_o
);

   localparam int c_cnt_max = (LOCK_TIMEOUT > DWELL_CYCLES) ? LOCK_TIMEOUT : DWELL_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   localparam logic [7:0]         c_init         = 8'(INIT_FREQ);
   localparam logic [7:0]         c_n_freq       = 8'(N_FREQ);
   localparam logic [7:0]         c_top          = 8'(N_FREQ - 1);
   localparam logic [7:0]         c_max_step     = 8'(MAX_STEP);
   localparam logic [c_cnt_w-1:0] c_holdoff      = c_cnt_w'(LOCK_HOLDOFF);
   localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_dwell_last   = c_cnt_w'(DWELL_CYCLES - 1);

`ifdef FREQ_REQ_STEP_LIMIT_EN
   localparam logic c_step_en = 1'b1;
`else
   localparam logic c_step_en = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_LOCK = 2'd2,
      ST_DWELL     = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [c_cnt_w-1:0] r_cnt;
   logic [7:0]         r_target;
   logic [7:0]         r_cur_freq;
   logic [7:0]         r_freq_data;
   logic               r_freq_valid;
   logic               r_range_err;
   logic               r_timeout_err;

   logic               w_accept;
   logic               w_req_oor;
   logic               w_issue;
   logic               w_timeout;
   logic               w_up;
   logic [7:0]         w_diff;
   logic [7:0]         w_step;
   logic [7:0]         w_next_idx;

   assign w_accept  = req.req_valid_i & req.req_ready_o;
   assign w_req_oor = (req.req_data_i >= c_n_freq);
   assign w_issue   = (r_state == ST_IDLE) && (r_target != r_cur_freq);

   // Without step limiting the whole distance is taken in one issue.
   always_comb begin
      w_up       = (r_target >= r_cur_freq);
      w_diff     = w_up ? (r_target - r_cur_freq) : (r_cur_freq - r_target);
      w_step     = (c_step_en && (w_diff > c_max_step)) ? c_max_step : w_diff;
      w_next_idx = w_up ? (r_cur_freq + w_step) : (r_cur_freq - w_step);
   end

   always_comb begin
      w_state_next = r_state;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_target != r_cur_freq) w_state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            w_state_next = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock is trusted only after the holdoff; a late lock beats the timeout.
            if ((r_cnt >= c_holdoff) && mmcm_locked_i) begin
               w_state_next = ST_DWELL;
            end else if (r_cnt == c_timeout_last) begin
               w_timeout    = 1'b1;
               w_state_next = ST_DWELL;
            end
         end
         ST_DWELL: begin
            if (r_cnt == c_dwell_last) w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         if ((w_state_next != r_state) || (r_state == ST_IDLE)) r_cnt <= '0;
         else                                                   r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_target      <= c_init;
         r_cur_freq    <= c_init;
         r_freq_data   <= c_init;
         r_freq_valid  <= 1'b0;
         r_range_err   <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_freq_valid <= w_issue;
         if (w_issue) begin
            r_freq_data <= w_next_idx;
            r_cur_freq  <= w_next_idx;
         end
         if (w_accept) begin
            r_target <= w_req_oor ? c_top : req.req_data_i;
            if (w_req_oor) r_range_err <= 1'b1;
         end
         if (w_timeout) r_timeout_err <= 1'b1;
      end
   end

   assign req.req_ready_o = (r_state == ST_IDLE) || (r_state == ST_DWELL);
   assign busy_o          = (r_state != ST_IDLE);
   assign freq_data_o     = r_freq_data;
   assign freq_valid_o    = r_freq_valid;
   assign cur_freq_o      = r_cur_freq;
   assign range_err_o     = r_range_err;
   assign timeout_err_o   = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_freq_req_governor.sv
// ============================================================================
// Module   : tb_freq_req_governor
// Brief    : Directed self-checking bench for freq_req_governor (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_req_governor;

   logic       clk = 1'b0;
   logic       rst;
   logic       mmcm_locked_i;
   logic [7:0] freq_data_o;
   logic       freq_valid_o;
   logic [7:0] cur_freq_o;
   logic       busy_o;
   logic       range_err_o;
   logic       timeout_err_o;

   int n_checks = 0;
   int n_fail   = 0;
   int n;
   int strobes;
   int busy_seen;

   localparam int c_limit = 10000;

   freq_req_if u_req_if ();

   freq_req_governor u_dut (
      .clk           (clk),
      .rst           (rst),
      .req           (u_req_if),
      .mmcm_locked_i (mmcm_locked_i),
      .freq_data_o   (freq_data_o),
      .freq_valid_o  (freq_valid_o),
      .cur_freq_o    (cur_freq_o),
      .busy_o        (busy_o),
      .range_err_o   (range_err_o),
      .timeout_err_o (timeout_err_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_req(input logic [7:0] d);
      u_req_if.req_valid_i = 1'b1;
      u_req_if.req_data_i  = d;
      step(1);
      u_req_if.req_valid_i = 1'b0;
   endtask

   task automatic wait_strobe(output int cnt);
      cnt = 0;
      do begin
         step(1);
         cnt++;
      end while (!freq_valid_o && cnt < c_limit);
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      do begin
         step(1);
         cnt++;
      end while (busy_o && cnt < c_limit);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_cur"},   int'(cur_freq_o),           19);
      check_eq({tag, "_data"},  int'(freq_data_o),          19);
      check_eq({tag, "_valid"}, int'(freq_valid_o),         0);
      check_eq({tag, "_busy"},  int'(busy_o),               0);
      check_eq({tag, "_rerr"},  int'(range_err_o),          0);
      check_eq({tag, "_terr"},  int'(timeout_err_o),        0);
      check_eq({tag, "_ready"}, int'(u_req_if.req_ready_o), 1);
   endtask

`ifdef FREQ_REQ_STEP_LIMIT_EN
   int exp_down[4] = '{15, 11, 7, 6};
   int exp_first_up = 9;
`else
   int exp_first_up = 19;
`endif

   initial begin
      rst                  = 1'b1;
      mmcm_locked_i        = 1'b1;
      u_req_if.req_valid_i = 1'b0;
      u_req_if.req_data_i  = 8'd0;
      step(3);
      check_reset_values("rst");
      rst = 1'b0;
      step(2);
      check_eq("idle_no_strobe", int'(freq_valid_o), 0);

      // Step down from the reset index to 6.
      send_req(8'd6);
      wait_strobe(n);
      check_eq("lat_6", n, 1);
`ifdef FREQ_REQ_STEP_LIMIT_EN
      check_eq("data_6_first", int'(freq_data_o), exp_down[0]);
      check_eq("cur_6_first",  int'(cur_freq_o),  exp_down[0]);
`else
      check_eq("data_6_first", int'(freq_data_o), 6);
      check_eq("cur_6_first",  int'(cur_freq_o),  6);
`endif
      check_eq("busy_issue",  int'(busy_o),               1);
      check_eq("ready_issue", int'(u_req_if.req_ready_o), 0);
      step(1);
      check_eq("pulse_width_6", int'(freq_valid_o),         0);
      check_eq("ready_wait",    int'(u_req_if.req_ready_o), 0);
      step(16);
      check_eq("holdoff_ready", int'(u_req_if.req_ready_o), 0);
      step(1);
      check_eq("lock_dwell_ready", int'(u_req_if.req_ready_o), 1);
      check_eq("lock_dwell_busy",  int'(busy_o),               1);
      step(3);
`ifdef FREQ_REQ_STEP_LIMIT_EN
      for (int i = 1; i < 4; i++) begin
         wait_strobe(n);
         check_eq($sformatf("gap_step%0d", i), n, (i == 1) ? 1022 : 1043);
         check_eq($sformatf("data_step%0d", i), int'(freq_data_o), exp_down[i]);
      end
      wait_idle(n);
      check_eq("idle_after_6", n, 1042);
`else
      wait_idle(n);
      check_eq("idle_after_6", n, 1021);
`endif
      check_eq("cur_6", int'(cur_freq_o), 6);
      check_eq("data_hold_6", int'(freq_data_o), 6);

      // Single-step change 6 -> 5 and full issue/lock/dwell duration.
      send_req(8'd5);
      wait_strobe(n);
      check_eq("lat_5",  n, 1);
      check_eq("data_5", int'(freq_data_o), 5);
      check_eq("cur_5",  int'(cur_freq_o),  5);
      wait_idle(n);
      check_eq("idle_after_5", n, 1042);

      // Out-of-range request is clamped to the top index.
      send_req(8'd30);
      check_eq("range_err_set", int'(range_err_o), 1);
      wait_strobe(n);
      check_eq("lat_30",  n, 1);
      check_eq("data_30", int'(freq_data_o), exp_first_up);
      for (int i = 0; i < 8 && !(cur_freq_o == 8'd19 && !busy_o); i++) wait_idle(n);
      check_eq("cur_clamped",   int'(cur_freq_o), 19);
      check_eq("busy_clamped",  int'(busy_o),     0);
      check_eq("range_err_hold", int'(range_err_o), 1);

      // Request equal to the current index does nothing.
      send_req(8'd19);
      strobes   = 0;
      busy_seen = 0;
      for (int i = 0; i < 30; i++) begin
         if (freq_valid_o) strobes++;
         if (busy_o) busy_seen++;
         step(1);
      end
      check_eq("same_no_strobe", strobes,   0);
      check_eq("same_no_busy",   busy_seen, 0);

      // Lock never arrives: timeout, then dwell, then idle.
      mmcm_locked_i = 1'b0;
      send_req(8'd15);
      wait_strobe(n);
      check_eq("lat_15",  n, 1);
      check_eq("data_15", int'(freq_data_o), 15);
      step(4096);
      check_eq("timeout_pre", int'(timeout_err_o), 0);
      step(1);
      check_eq("timeout_set",   int'(timeout_err_o),        1);
      check_eq("timeout_dwell", int'(u_req_if.req_ready_o), 1);
      wait_idle(n);
      check_eq("idle_after_timeout", n, 1024);
      mmcm_locked_i = 1'b1;
      step(2);
      check_eq("timeout_sticky", int'(timeout_err_o), 1);
      check_eq("range_sticky",   int'(range_err_o),   1);

      // Asynchronous reset while waiting for lock.
      send_req(8'd17);
      wait_strobe(n);
      check_eq("lat_17",  n, 1);
      check_eq("data_17", int'(freq_data_o), 17);
      step(5);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("ready_after_release", int'(u_req_if.req_ready_o), 1);
      strobes   = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (freq_valid_o) strobes++;
         if (busy_o) busy_seen++;
      end
      check_eq("post_rst_no_strobe", strobes,   0);
      check_eq("post_rst_no_busy",   busy_seen, 0);
      check_eq("post_rst_cur",       int'(cur_freq_o), 19);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/freq_req_governor.md
FREQ_REQ_GOVERNOR -- requirements
Module: freq_req_governor

Interface
REQ-001 Parameter N_FREQ, 20: number of valid frequency indices (0..N_FREQ-1).
REQ-002 Parameter INIT_FREQ, 19: index assumed active after reset.
REQ-003 Parameter LOCK_HOLDOFF, 16: cycles ignored after an issue before mmcm_locked_i is sampled.
REQ-004 Parameter LOCK_TIMEOUT, 4096: cycles allowed for lock before timeout.
REQ-005 Parameter DWELL_CYCLES, 1024: minimum cycles between consecutive issues once locked.
REQ-006 Parameter MAX_STEP, 4: largest index change per issue when step limiting is compiled in.
REQ-007 clk  in  1  single clock; all logic rising-edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 req_valid_i  in  1  target-frequency request strobe.
REQ-010 req_data_i  in  8  requested target index.
REQ-011 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-012 mmcm_locked_i  in  1  lock status from the clock manager.
REQ-013 freq_data_o  out  8  index sent to the clock manager's freq_data_in.
REQ-014 freq_valid_o  out  1  one-cycle strobe to the clock manager's freq_valid_in.
REQ-015 cur_freq_o  out  8  last index issued.
REQ-016 busy_o  out  1  high in every state except IDLE.
REQ-017 range_err_o  out  1  sticky: an out-of-range request was seen.
REQ-018 timeout_err_o  out  1  sticky: lock not seen within LOCK_TIMEOUT.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_LOCK and DWELL.
REQ-020 req_ready_o SHALL be high in IDLE and DWELL and low in ISSUE and WAIT_LOCK.
REQ-021 An accepted request SHALL overwrite the target register, so the latest request wins.
REQ-022 A request with req_data_i >= N_FREQ SHALL be clamped to N_FREQ-1 and SHALL set range_err_o.
REQ-023 IDLE: if target != cur_freq_o, the FSM SHALL go to ISSUE on the next cycle; otherwise it SHALL stay in IDLE.
REQ-024 ISSUE: for exactly one cycle, freq_valid_o SHALL be 1, freq_data_o SHALL equal the next index, and cur_freq_o SHALL take the next index on that edge; the FSM SHALL then go to WAIT_LOCK.
REQ-025 WAIT_LOCK: for LOCK_HOLDOFF cycles, mmcm_locked_i SHALL be ignored; the FSM SHALL go to DWELL on the first cycle after that with mmcm_locked_i=1.
REQ-026 If LOCK_TIMEOUT cycles elapse in WAIT_LOCK without lock, the FSM SHALL set timeout_err_o and go to DWELL.
REQ-027 DWELL: after DWELL_CYCLES cycles, the FSM SHALL go to IDLE.
REQ-028 A request accepted in the final DWELL cycle SHALL be evaluated in IDLE on the following cycle.
REQ-029 Request latency from acceptance in IDLE to freq_valid_o SHALL be 2 cycles.
REQ-030 freq_data_o SHALL hold its last value between strobes.
REQ-031 The counter SHALL be a single counter sized for max(LOCK_TIMEOUT, DWELL_CYCLES) and cleared on every state entry.
REQ-032 Error flags SHALL clear only on rst.

Reset
REQ-033 rst SHALL asynchronously force state=IDLE, target=INIT_FREQ, cur_freq_o=INIT_FREQ, freq_data_o=INIT_FREQ, freq_valid_o=0, busy_o=0, range_err_o=0, timeout_err_o=0, counter=0.
REQ-034 rst asserted mid-ISSUE or mid-WAIT_LOCK SHALL abort without any further freq_valid_o pulse; req_ready_o SHALL be 1 on the first cycle after release.

Configuration
REQ-035 With macro FREQ_REQ_STEP_LIMIT_EN defined, the next index SHALL be cur ± min(|target-cur|, MAX_STEP), repeating issue/lock/dwell cycles until cur equals target.
REQ-036 Without FREQ_REQ_STEP_LIMIT_EN, the next index SHALL equal target directly, giving one issue per change.

Verification
REQ-037 Reset, then request 5 in IDLE -> 2 cycles later freq_valid_o=1 for 1 cycle with freq_data_o=5; cur_freq_o=5.
REQ-038 Request 19 while cur=19 -> no freq_valid_o pulse and busy_o stays 0.
REQ-039 Request 30 -> range_err_o=1 and issued index 19; range_err_o persists until rst.
REQ-040 Hold mmcm_locked_i=0 after an issue -> timeout_err_o=1 after LOCK_TIMEOUT cycles, then DWELL, then IDLE.
REQ-041 With the macro, cur=19, request 6 -> issues 15, 11, 7, 6, each separated by lock plus DWELL_CYCLES; without the macro, a single issue of 6.
REQ-042 Assert rst during WAIT_LOCK -> all outputs at reset values immediately; no strobe after release.
